decode_stage: RTL

//  ID stage of the 5-stage RV32I pipeline, directly downstream of fetch. Consumes instrD/PCD/PCPlus4D,

---
 rtl/rv_pkg.sv | 76 +++++++
 rtl/decode_stage_if.sv | 48 ++++
 rtl/decode_stage_reg_file.sv | 39 +++
 rtl/decode_stage.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/result-select encodings and the ID/EX register layout.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        jalr;
    logic        branch;
    result_src_e result_src;
    logic        alu_src_a;
    logic        alu_src_b;
    alu_ctrl_e   alu_control;
    logic        illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
  } idex_t;

  // funct7[5] only selects SUB for register-register ops; immediates reuse it solely for SRAI.
  function automatic alu_ctrl_e alu_op(input logic [2:0] f3, input logic alt, input logic is_r);
    case (f3)
      3'b000:  return (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/writeback/hazard inputs and ID/EX outputs of the decode stage, bundled for port wiring.
interface decode_stage_if;

  logic [31:0] instrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        flush_E;

  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmExtE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        JumpE;
  logic        JalrE;
  logic        BranchE;
  logic [1:0]  ResultSrcE;
  logic        ALUSrcAE;
  logic        ALUSrcBE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;
  logic        IllegalE;

  modport master (
    output instrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, flush_E,
    input  Rs1D, Rs2D, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
    input  RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ResultSrcE,
    input  ALUSrcAE, ALUSrcBE, ALUControlE, Funct3E, IllegalE
  );

  modport slave (
    input  instrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, flush_E,
    output Rs1D, Rs2D, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
    output RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ResultSrcE,
    output ALUSrcAE, ALUSrcBE, ALUControlE, Funct3E, IllegalE
  );

endinterface

// File: rtl/decode_stage_reg_file.sv
// 2-read/1-write architectural register file with write-first bypass; x0 reads as zero.
module reg_file #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter bit CLR_RF = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we && waddr != 5'd0) regs_d[waddr] = wdata;
  end

  // With clearing enabled, reset also wins over a writeback landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset && CLR_RF) regs_q <= '{default: '0};
    else                 regs_q <= regs_d;
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != 5'd0) rdata1 = (we && waddr == raddr1) ? wdata : regs_q[raddr1];
    if (raddr2 != 5'd0) rdata2 = (we && waddr == raddr2) ? wdata : regs_q[raddr2];
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: control decode, register read, immediate generation and the ID/EX register.
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter bit CLR_RF = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  decode_stage_if.slave  bus
);

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [31:0] rd1, rd2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  ctrl_t       ctrl;
  logic [31:0] imm;
  idex_t       idex_d, idex_q;

  assign instr    = bus.instrD;
  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign bus.Rs1D = instr[19:15];
  assign bus.Rs2D = instr[24:20];

  reg_file #(.XLEN(XLEN), .NREGS(NREGS), .CLR_RF(CLR_RF)) u_reg_file (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (instr[19:15]),
    .raddr2 (instr[24:20]),
    .rdata1 (rd1),
    .rdata2 (rd2),
    .we     (bus.RegWriteW),
    .waddr  (bus.RdW),
    .wdata  (bus.ResultW)
  );

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    ctrl = '0;
    imm  = '0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = alu_op(instr[14:12], instr[30], 1'b1);
      end
      OP_I: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_b   = 1'b1;
        ctrl.alu_control = alu_op(instr[14:12], instr[30], 1'b0);
        imm              = imm_i;
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.result_src = RES_MEM;
        imm             = imm_i;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        imm            = imm_s;
      end
      OP_BRANCH: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
        imm              = imm_b;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        imm             = imm_j;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jalr       = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.result_src = RES_PC4;
        imm             = imm_i;
      end
      OP_LUI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_b   = 1'b1;
        ctrl.alu_control = ALU_PASSB;
        imm              = imm_u;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 1'b1;
        imm            = imm_u;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    if (rd == 5'd0) ctrl.reg_write = 1'b0;
  end

  // A flushed slot is an all-zero bundle, which execute treats as a NOP.
  always_comb begin
    idex_d = '0;
    if (!bus.flush_E) begin
      idex_d.ctrl   = ctrl;
      idex_d.rd1    = rd1;
      idex_d.rd2    = rd2;
      idex_d.imm    = imm;
      idex_d.pc     = bus.PCD;
      idex_d.pc4    = bus.PCPlus4D;
      idex_d.rs1    = instr[19:15];
      idex_d.rs2    = instr[24:20];
      idex_d.rd     = rd;
      idex_d.funct3 = instr[14:12];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign bus.RD1E        = idex_q.rd1;
  assign bus.RD2E        = idex_q.rd2;
  assign bus.ImmExtE     = idex_q.imm;
  assign bus.PCE         = idex_q.pc;
  assign bus.PCPlus4E    = idex_q.pc4;
  assign bus.Rs1E        = idex_q.rs1;
  assign bus.Rs2E        = idex_q.rs2;
  assign bus.RdE         = idex_q.rd;
  assign bus.Funct3E     = idex_q.funct3;
  assign bus.RegWriteE   = idex_q.ctrl.reg_write;
  assign bus.MemWriteE   = idex_q.ctrl.mem_write;
  assign bus.JumpE       = idex_q.ctrl.jump;
  assign bus.JalrE       = idex_q.ctrl.jalr;
  assign bus.BranchE     = idex_q.ctrl.branch;
  assign bus.ResultSrcE  = idex_q.ctrl.result_src;
  assign bus.ALUSrcAE    = idex_q.ctrl.alu_src_a;
  assign bus.ALUSrcBE    = idex_q.ctrl.alu_src_b;
  assign bus.ALUControlE = idex_q.ctrl.alu_control;
  assign bus.IllegalE    = idex_q.ctrl.illegal;

endmodule
